// File: rtl/posit_regime_decode_pipe_if.sv
// Stream bundle for the posit regime decoder: raw posit word in, decoded fields out.
// Latency: none, wiring only.
// Backpressure: valid/ready on both sides; ready flows upstream from the output.
interface posit_regime_decode_pipe_if #(
    parameter int N  = 32,
    parameter int ES = 2
);
    localparam int RW = $clog2(N);
    localparam int KW = RW + 1;
    // A zero-width exponent port cannot exist, so ES=0 keeps one bit tied to 0.
    localparam int EW = (ES > 0) ? ES : 1;
    localparam int FW = N - 1 - ES;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic          out_zero;
    logic          out_nar;
    logic [RW-1:0] out_run;
    logic [KW-1:0] out_k;
    logic [EW-1:0] out_exp;
    logic [FW-1:0] out_frac;

    // Producer of raw words and consumer of decoded results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_zero, out_nar,
        input  out_run, out_k, out_exp, out_frac
    );

    // The decoder itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_zero, out_nar,
        output out_run, out_k, out_exp, out_frac
    );
endinterface

// File: rtl/posit_regime_decode_pipe.sv
// Posit decoder front end: sign/zero/NaR flags, regime run length and k, exponent and fraction.
// Latency: 2 cycles from the accepting handshake to out_valid, 1 word per cycle sustained.
// Backpressure: each stage loads when empty or draining; in_ready depends on out_ready, never on in_valid.
module posit_regime_decode_pipe #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    posit_regime_decode_pipe_if.slave bus
);
    localparam int RW   = $clog2(N);
    localparam int KW   = RW + 1;
    localparam int EW   = (ES > 0) ? ES : 1;
    localparam int VW   = N - 1;
    localparam int FW   = N - 1 - ES;
    // Run counting works on 8-bit slices; at least one pad bit always exists.
    localparam int NSEG = (VW / 8) + 1;
    localparam int PW   = NSEG * 8;

    // Leading-zero count of one slice; an all-zero slice is flagged separately.
    function automatic logic [2:0] lead_zeros8(input logic [7:0] s);
        logic [2:0] lz;
        lz = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) lz = 3'(7 - i);
        end
        return lz;
    endfunction

    // ---------------- stage 1 combinational: magnitude, flags, run length ----------------
    logic            in_sign;
    logic [VW-1:0]   in_v;
    logic            in_zero;
    logic            in_nar;
    logic [PW-1:0]   run_src;
    logic [NSEG-1:0] seg_zero;
    logic [2:0]      seg_lz [NSEG];
    logic [RW-1:0]   in_run;

    assign in_sign = bus.in_data[N-1];
    // Only the low N-1 bits of the magnitude are kept, and those equal the
    // negation of the low N-1 input bits modulo 2^(N-1).
    assign in_v    = in_sign ? (~bus.in_data[VW-1:0] + VW'(1)) : bus.in_data[VW-1:0];
    assign in_zero = (bus.in_data == '0);
    assign in_nar  = (bus.in_data == {1'b1, {VW{1'b0}}});
    // Bits equal to the regime bit become zeros; the ones padding stops the
    // count at VW when the whole field is one run.
    assign run_src = {(in_v[VW-1] ? ~in_v : in_v), {(PW - VW){1'b1}}};

    generate
        for (genvar g = 0; g < NSEG; g++) begin : g_seg
            assign seg_zero[g] = (run_src[PW-1-8*g -: 8] == 8'h00);
            assign seg_lz[g]   = lead_zeros8(run_src[PW-1-8*g -: 8]);
        end
    endgenerate

    // Merge slices: each all-zero slice adds 8 until the first slice holding a one.
    always_comb begin
        logic hit;
        hit    = 1'b0;
        in_run = '0;
        for (int s = 0; s < NSEG; s++) begin
            if (!hit) begin
                if (seg_zero[s]) begin
                    in_run = in_run + RW'(8);
                end else begin
                    in_run = in_run + RW'(seg_lz[s]);
                    hit    = 1'b1;
                end
            end
        end
    end

    // ---------------- flow control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_take;
    logic in_ready_c;

    assign s2_take      = !s2_valid_q || bus.out_ready;
    assign in_ready_c   = !rst && (!s1_valid_q || s2_take);
    assign bus.in_ready = in_ready_c;

    // ---------------- stage 1 registers ----------------
    logic          s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d;
    logic          s1_nar_q,  s1_nar_d;
    logic [VW-1:0] s1_v_q,    s1_v_d;
    logic [RW-1:0] s1_run_q,  s1_run_d;

    // Stage 1 next state: take a new word on handshake, go empty when it only drains.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        s1_v_d     = s1_v_q;
        s1_run_d   = s1_run_q;
        if (in_ready_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = in_zero;
                s1_nar_d  = in_nar;
                s1_v_d    = in_v;
                s1_run_d  = in_run;
            end
        end
    end

    // Stage 1 state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_v_q     <= '0;
            s1_run_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s1_v_q     <= s1_v_d;
            s1_run_q   <= s1_run_d;
        end
    end

    // ---------------- stage 2 combinational: k, remainder split ----------------
    logic [KW-1:0] s1_run_ext;
    logic [KW-1:0] k_c;
    logic [VW-1:0] rem_c;
    logic [EW-1:0] exp_c;
    logic [FW-1:0] frac_c;
    logic          special_c;

    assign s1_run_ext = {1'b0, s1_run_q};
    // Regime of ones gives k = run-1, regime of zeros gives k = -run.
    assign k_c        = s1_v_q[VW-1] ? (s1_run_ext - KW'(1)) : (~s1_run_ext + KW'(1));
    assign special_c  = s1_zero_q || s1_nar_q;

    // Drop the run and its terminating bit; nothing is left once the run reaches N-2.
    always_comb begin
        rem_c = '0;
        if (int'(s1_run_q) < (N - 2)) begin
            rem_c = s1_v_q << (s1_run_ext + KW'(1));
        end
    end

    generate
        if (ES > 0) begin : g_exp
            assign exp_c = rem_c[VW-1 -: EW];
        end else begin : g_no_exp
            assign exp_c = '0;
        end
    endgenerate
    assign frac_c = rem_c[FW-1:0];

    // ---------------- stage 2 registers (drive the outputs) ----------------
    logic          s2_sign_q, s2_sign_d;
    logic          s2_zero_q, s2_zero_d;
    logic          s2_nar_q,  s2_nar_d;
    logic [RW-1:0] s2_run_q,  s2_run_d;
    logic [KW-1:0] s2_k_q,    s2_k_d;
    logic [EW-1:0] s2_exp_q,  s2_exp_d;
    logic [FW-1:0] s2_frac_q, s2_frac_d;

    // Stage 2 next state: hold while stalled, otherwise take stage 1 (zero/NaR clear the fields).
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_nar_d   = s2_nar_q;
        s2_run_d   = s2_run_q;
        s2_k_d     = s2_k_q;
        s2_exp_d   = s2_exp_q;
        s2_frac_d  = s2_frac_q;
        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                s2_zero_d = s1_zero_q;
                s2_nar_d  = s1_nar_q;
                if (special_c) begin
                    s2_run_d  = '0;
                    s2_k_d    = '0;
                    s2_exp_d  = '0;
                    s2_frac_d = '0;
                end else begin
                    s2_run_d  = s1_run_q;
                    s2_k_d    = k_c;
                    s2_exp_d  = exp_c;
                    s2_frac_d = frac_c;
                end
            end
        end
    end

    // Stage 2 state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_run_q   <= '0;
            s2_k_q     <= '0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_nar_q   <= s2_nar_d;
            s2_run_q   <= s2_run_d;
            s2_k_q     <= s2_k_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= s2_frac_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_nar   = s2_nar_q;
    assign bus.out_run   = s2_run_q;
    assign bus.out_k     = s2_k_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_frac  = s2_frac_q;
endmodule

// File: tb/tb_posit_regime_decode_pipe.sv
// Directed bench for the posit regime decoder: N=32/ES=2 vectors, backpressure, reset, N=8/ES=0 sweep.
// Latency: checks out_valid exactly 2 cycles after the accepting handshake.
// Backpressure: stalls out_ready and checks in_ready, output hold and ordering.
module tb_posit_regime_decode_pipe;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    posit_regime_decode_pipe_if #(.N(32), .ES(2)) bus32 ();
    posit_regime_decode_pipe_if #(.N(8),  .ES(0)) bus8 ();

    posit_regime_decode_pipe #(.N(32), .ES(2)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    posit_regime_decode_pipe #(.N(8),  .ES(0)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic        sign;
        logic        zero;
        logic        nar;
        int          run;
        int          k;
        logic [63:0] ex;
        logic [63:0] fr;
    } ref_t;

    // Straight bit-by-bit reading of the decode rules.
    function automatic ref_t model(input int n, input int es, input logic [63:0] x);
        ref_t        r;
        logic [63:0] m, v, rem;
        logic        rb;
        int          run;
        r.sign = x[n-1];
        r.zero = (x == 64'd0);
        r.nar  = (x == (64'd1 << (n - 1)));
        m      = r.sign ? ((~x + 64'd1) & ((64'd1 << n) - 64'd1)) : x;
        v      = m & ((64'd1 << (n - 1)) - 64'd1);
        rb     = v[n-2];
        run    = 0;
        for (int i = n - 2; i >= 0; i--) begin
            if (v[i] != rb) break;
            run++;
        end
        r.run = run;
        r.k   = rb ? run - 1 : -run;
        rem   = (run >= n - 2) ? 64'd0 : ((v << (run + 1)) & ((64'd1 << (n - 1)) - 64'd1));
        r.ex  = (es > 0) ? (rem >> (n - 1 - es)) : 64'd0;
        r.fr  = rem & ((64'd1 << (n - 1 - es)) - 64'd1);
        if (r.zero || r.nar) begin
            r.run = 0;
            r.k   = 0;
            r.ex  = 64'd0;
            r.fr  = 64'd0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pack32();
        return 64'({bus32.out_valid, bus32.out_sign, bus32.out_zero, bus32.out_nar,
                    bus32.out_run, bus32.out_k, bus32.out_exp, bus32.out_frac});
    endfunction

    function automatic logic [63:0] pack8();
        return 64'({bus8.out_valid, bus8.out_sign, bus8.out_zero, bus8.out_nar,
                    bus8.out_run, bus8.out_k, bus8.out_exp, bus8.out_frac});
    endfunction

    task automatic cmp_ref(input string tag, input ref_t e, input logic [63:0] s, z, na,
                           input int run, k, input logic [63:0] ex, fr);
        chk({tag, ".sign"}, s,          64'(e.sign));
        chk({tag, ".zero"}, z,          64'(e.zero));
        chk({tag, ".nar"},  na,         64'(e.nar));
        chk({tag, ".run"},  64'(run),   64'(e.run));
        chk({tag, ".k"},    64'(k),     64'(e.k));
        chk({tag, ".exp"},  ex,         e.ex);
        chk({tag, ".frac"}, fr,         e.fr);
    endtask

    // One isolated word on the 32-bit decoder with hand-computed fields.
    task automatic single(input string tag, input logic [31:0] w, input logic s, z, na,
                          input int run, k, input logic [1:0] ex, input logic [28:0] fr);
        bus32.in_valid  = 1'b1;
        bus32.in_data   = w;
        bus32.out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.in_data  = 32'h0;
        chk({tag, ".lat1_valid"}, 64'(bus32.out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".lat2_valid"}, 64'(bus32.out_valid), 64'd1);
        chk({tag, ".sign"}, 64'(bus32.out_sign), 64'(s));
        chk({tag, ".zero"}, 64'(bus32.out_zero), 64'(z));
        chk({tag, ".nar"},  64'(bus32.out_nar),  64'(na));
        chk({tag, ".run"},  64'(bus32.out_run),  64'(run));
        chk({tag, ".k"},    64'(int'($signed(bus32.out_k))), 64'(k));
        chk({tag, ".exp"},  64'(bus32.out_exp),  64'(ex));
        chk({tag, ".frac"}, 64'(bus32.out_frac), 64'(fr));
        @(posedge clk); #1;
    endtask

    logic [31:0] bpw [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          sent, got, occ, lowcnt, appeared, cyc;
        logic        held;
        logic [63:0] prev;
        ref_t        e;

        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_data   = 32'h0;
        bus32.out_ready = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.in_data    = 8'h0;
        bus8.out_ready  = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready32", 64'(bus32.in_ready), 64'd0);
        chk("rst.in_ready8",  64'(bus8.in_ready),  64'd0);
        chk("rst.out32", pack32(), 64'd0);
        chk("rst.out8",  pack8(),  64'd0);
        rst             = 1'b0;
        bus32.out_ready = 1'b1;
        #1;
        chk("post_rst.in_ready32", 64'(bus32.in_ready), 64'd1);
        chk("post_rst.in_ready8",  64'(bus8.in_ready),  64'd1);
        @(posedge clk); #1;

        // Directed words, each with the 2-cycle latency check.
        single("v40000000", 32'h40000000, 1'b0, 1'b0, 1'b0,  1,   0, 2'b00, 29'h0);
        single("v00000001", 32'h00000001, 1'b0, 1'b0, 1'b0, 30, -30, 2'b00, 29'h0);
        single("v7FFFFFFF", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 31,  30, 2'b00, 29'h0);
        single("v48000000", 32'h48000000, 1'b0, 1'b0, 1'b0,  1,   0, 2'b01, 29'h0);
        single("vC0000000", 32'hC0000000, 1'b1, 1'b0, 1'b0,  1,   0, 2'b00, 29'h0);
        single("v00000000", 32'h00000000, 1'b0, 1'b1, 1'b0,  0,   0, 2'b00, 29'h0);
        single("v80000000", 32'h80000000, 1'b1, 1'b0, 1'b1,  0,   0, 2'b00, 29'h0);
        single("vFFFFFFFF", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 30, -30, 2'b00, 29'h0);
        single("vF0000000", 32'hF0000000, 1'b1, 1'b0, 1'b0,  2,  -2, 2'b00, 29'h0);
        single("v5A5A5A5A", 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0,  1,   0, 2'b11, 29'h09696968);

        // Backpressure: six words streamed, out_ready low in cycles 3..6.
        bpw[0] = 32'h40000000; bpw[1] = 32'h48000000; bpw[2] = 32'hC0000000;
        bpw[3] = 32'h5A5A5A5A; bpw[4] = 32'h7FFFFFFF; bpw[5] = 32'h00000001;
        sent = 0; got = 0; lowcnt = 0; held = 1'b0; prev = 64'd0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            occ             = sent - got;
            bus32.out_ready = !(c >= 3 && c <= 6);
            bus32.in_valid  = (sent < 6);
            bus32.in_data   = bpw[(sent < 6) ? sent : 5];
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), 64'(bus32.in_ready),
                64'((occ < 2) || bus32.out_ready));
            if (!bus32.in_ready) lowcnt++;
            if (held) chk($sformatf("bp_hold_c%0d", c), pack32(), prev);
            if (bus32.out_valid && bus32.out_ready) begin
                e = model(32, 2, 64'(bpw[got]));
                cmp_ref($sformatf("bp_w%0d", got), e, 64'(bus32.out_sign), 64'(bus32.out_zero),
                        64'(bus32.out_nar), int'(bus32.out_run), int'($signed(bus32.out_k)),
                        64'(bus32.out_exp), 64'(bus32.out_frac));
                got++;
            end
            held = bus32.out_valid && !bus32.out_ready;
            prev = pack32();
            if (bus32.in_valid && bus32.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        chk("bp_all_emerged", 64'(got), 64'd6);
        chk("bp_stall_cycles", 64'(lowcnt), 64'd4);

        // Reset mid-stream: two words accepted and held, then reset.
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_data   = 32'h40000000;
        #1;
        chk("rms.acc0_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;
        bus32.in_data = 32'h7FFFFFFF;
        #1;
        chk("rms.acc1_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        rst            = 1'b1;
        #1;
        chk("rms.in_ready_in_rst", 64'(bus32.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rms.out_cleared", pack32(), 64'd0);
        @(posedge clk); #1;
        rst             = 1'b0;
        bus32.out_ready = 1'b1;
        appeared        = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus32.out_valid) appeared++;
            @(posedge clk); #1;
        end
        chk("rms.no_output", 64'(appeared), 64'd0);

        // N=8, ES=0: every input streamed back to back.
        sent = 0; got = 0; cyc = 0;
        while (got < 256 && cyc < 400) begin
            bus8.in_valid  = (sent < 256);
            bus8.in_data   = 8'(sent);
            bus8.out_ready = 1'b1;
            #1;
            if (bus8.out_valid) begin
                e = model(8, 0, 64'(got));
                cmp_ref($sformatf("n8_%02h", got), e, 64'(bus8.out_sign), 64'(bus8.out_zero),
                        64'(bus8.out_nar), int'(bus8.out_run), int'($signed(bus8.out_k)),
                        64'(bus8.out_exp), 64'(bus8.out_frac));
                got++;
            end
            if (bus8.in_valid && bus8.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus8.in_valid = 1'b0;
        chk("n8_count", 64'(got), 64'd256);
        chk("n8_throughput_cycles", 64'(cyc), 64'd258);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/posit_regime_decode_pipe.md
POSIT_REGIME_DECODE_PIPE -- requirements
Module: posit_regime_decode_pipe

Interface
REQ-001 SHALL have parameter N, default 32, meaning posit word width; legal range 8..64.
REQ-002 SHALL have parameter ES, default 2, meaning exponent field width; legal range 0..N-4.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_data is valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  N  meaning the raw posit word.
REQ-008 SHALL have port out_valid  output  1  meaning the decoded result is valid.
REQ-009 SHALL have port out_ready  input  1  meaning the downstream block accepts the result.
REQ-010 SHALL have port out_sign  output  1  meaning in_data[N-1].
REQ-011 SHALL have port out_zero  output  1  meaning in_data was all-zero.
REQ-012 SHALL have port out_nar  output  1  meaning in_data was 1 followed by N-1 zeros.
REQ-013 SHALL have port out_run  output  clog2(N)  meaning the regime run length, unsigned.
REQ-014 SHALL have port out_k  output  clog2(N)+1  meaning the regime value, two's complement.
REQ-015 SHALL have port out_exp  output  ES  meaning the exponent bits (absent when ES=0).
REQ-016 SHALL have port out_frac  output  N-1-ES  meaning the fraction bits, left-aligned, zero-padded.

Function
REQ-017 SHALL define the handshake: a transfer occurs when valid and ready are both high in the same cycle.
REQ-018 SHALL form the magnitude m = in_data when sign=0, else the two's complement of in_data; v = m[N-2:0].
REQ-019 SHALL compute r = v[N-2] and run = number of consecutive bits equal to r starting at v[N-2]; maximum run is N-1.
REQ-020 SHALL compute k = run-1 when r=1, else k = -run.
REQ-021 SHALL compute rem = (v << (run+1)) truncated to N-1 bits, and rem = 0 when run >= N-2.
REQ-022 SHALL drive out_exp = rem[N-2 -: ES] and out_frac = rem[N-2-ES:0].
REQ-023 SHALL force out_run, out_k, out_exp and out_frac to 0 when out_zero or out_nar is set; out_sign SHALL still equal in_data[N-1].
REQ-024 SHALL be a 2-stage pipeline: stage 1 registers the magnitude and flags plus a segmented leading-run count (priority encoders of 4-8 bit slices, merged); stage 2 registers k, run, exp and frac.
REQ-025 SHALL present out_valid 2 cycles after the accepting edge when out_ready is held high.
REQ-026 SHALL sustain a throughput of 1 word per cycle when there is no backpressure.
REQ-027 SHALL let each stage register load when that stage is empty or its contents move downstream in the same cycle.
REQ-028 SHALL drive in_ready = !s1_valid || (stage 1 advances this cycle).
REQ-029 SHALL drive in_ready combinationally from out_ready; no combinational path from in_valid to in_ready is permitted.
REQ-030 SHALL hold all out_* signals stable while out_valid=1 and out_ready=0.
REQ-031 SHALL preserve order, with no word dropped or duplicated, under any valid/ready pattern.
REQ-032 SHALL, when out_ready=0 and both stages are full, drive in_ready=0.
REQ-033 SHALL, on the cycle out_ready returns high, shift both stages and assert in_ready.
REQ-034 SHALL ignore in_data while in_valid=0.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, clear both stage valid bits.
REQ-036 SHALL, while rst=1 at a clock edge, zero all data registers.
REQ-037 SHALL hold out_valid=0 and all out_* data at 0 from the first edge with rst=1.
REQ-038 SHALL drive in_ready=0 while rst=1.
REQ-039 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-040 SHALL, on reset mid-stream, discard in-flight words, which never appear at the output.

Verification
REQ-041 SHALL verify (N=32, ES=2) 0x40000000: response sign=0, run=1, k=0, exp=0, frac=0, out_valid exactly 2 cycles after accept.
REQ-042 SHALL verify 0x00000001 -> run=30, k=-30, rem=0; verify 0x7FFFFFFF -> run=31, k=30, rem=0; verify 0x48000000 -> run=1, k=0, exp=2'b01, frac=0.
REQ-043 SHALL verify 0xC0000000 -> sign=1, k=0, run=1; verify 0x00000000 -> zero=1, k=0; verify 0x80000000 -> nar=1, k=0, run=0.
REQ-044 SHALL verify backpressure: stream 6 words with out_ready=0 for cycles 3-6 -> in_ready drops once 2 words are held, outputs stay stable, all 6 emerge in order.
REQ-045 SHALL verify reset mid-stream: assert rst 1 cycle after 2 accepts -> out_valid stays 0 and neither word ever appears.
REQ-046 SHALL verify N=8, ES=0 exhaustively: all 256 inputs checked against the REQ-018..023 reference model.
